// File: rtl/deser400_pkg.sv
// Shared deser400 definitions: phase geometry and mod-4 phase arithmetic.
package deser400_pkg;

  localparam int unsigned NUM_PHASES = 4;
  localparam int unsigned PHASE_W    = 2;

  typedef logic [PHASE_W-1:0] phase_t;

  // Forward distance from cur to target, modulo NUM_PHASES.
  function automatic phase_t phase_dist(input phase_t cur, input phase_t target);
    return phase_t'(target - cur);
  endfunction

  // One step toward target; a half-turn away always steps forward.
  function automatic phase_t phase_step(input phase_t cur, input phase_t target);
    phase_t d;
    d = phase_dist(cur, target);
    if (d == 2'd0) begin
      return cur;
    end else if (d == 2'd3) begin
      return phase_t'(cur - 2'd1);
    end else begin
      return phase_t'(cur + 2'd1);
    end
  endfunction

endpackage

// File: rtl/edge_histogram.sv
// Per-window edge histogram over the four oversampled phases of each bit period.
module edge_histogram import deser400_pkg::*; #(
  parameter int unsigned WINDOW_LOG2 = 6
) (
  input  logic                                    clk400,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic [NUM_PHASES-1:0]                   din,
  output logic [NUM_PHASES-1:0]                   din_d,
  output logic [NUM_PHASES-1:0][WINDOW_LOG2:0]    counts,
  output logic                                    window_done
);

  logic [NUM_PHASES-1:0]                din_d_q;
  logic [NUM_PHASES-1:0]                edges;
  logic [NUM_PHASES-1:0][WINDOW_LOG2:0] cnt_q;
  logic [WINDOW_LOG2-1:0]               timer_q;

  always_comb begin
    edges[0] = din[0] ^ din_d_q[NUM_PHASES-1];
    for (int k = 1; k < NUM_PHASES; k++) begin
      edges[k] = din[k] ^ din[k-1];
    end
  end

  // Counts include this cycle's edges so the closing cycle is part of the evaluation.
  always_comb begin
    for (int k = 0; k < NUM_PHASES; k++) begin
      counts[k] = cnt_q[k] + (WINDOW_LOG2+1)'(edges[k]);
    end
  end

  assign window_done = enable & (&timer_q);
  assign din_d       = din_d_q;

  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) begin
      din_d_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      din_d_q <= din;
      if (!enable) begin
        cnt_q   <= '0;
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + WINDOW_LOG2'(1);
        cnt_q   <= window_done ? '0 : counts;
      end
    end
  end

endmodule

// File: rtl/phase_selector.sv
// Sampling-phase selection with hysteresis for the deser400 clock/data recovery stage.
module phase_selector import deser400_pkg::*; #(
  parameter int unsigned WINDOW_LOG2 = 6,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned EDGE_MIN    = 4
) (
  input  logic                  clk400,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_PHASES-1:0] din,
  output logic                  sdata,
  output logic [PHASE_W-1:0]    phase,
  output logic                  locked,
  output logic                  phase_upd,
  output logic                  slip
);

  localparam int unsigned SumW  = WINDOW_LOG2 + 3;
  localparam int unsigned LockW = $clog2(LOCK_COUNT + 1);

  logic [NUM_PHASES-1:0]                din_d;
  logic [NUM_PHASES-1:0][WINDOW_LOG2:0] counts;
  logic                                 window_done;

  edge_histogram #(
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_hist (
    .clk400      (clk400),
    .reset       (reset),
    .enable      (enable),
    .din         (din),
    .din_d       (din_d),
    .counts      (counts),
    .window_done (window_done)
  );

  phase_t           dom, cand;
  logic [WINDOW_LOG2:0] best;
  logic [SumW-1:0]  total;

  always_comb begin
    dom   = '0;
    best  = counts[0];
    total = '0;
    // Strict compare keeps the lowest index on ties.
    for (int k = 1; k < NUM_PHASES; k++) begin
      if (counts[k] > best) begin
        best = counts[k];
        dom  = phase_t'(k);
      end
    end
    for (int k = 0; k < NUM_PHASES; k++) begin
      total = total + SumW'(counts[k]);
    end
    cand = phase_t'(dom + 2'd2);
  end

  logic [LockW-1:0] lock_cnt_q, lock_cnt_d, lock_next;
  phase_t           prev_q, prev_d, phase_q, phase_d;
  logic             prev_valid_q, prev_valid_d;
  logic             locked_q, locked_d, upd_q, upd_d, slip_q, slip_d, sdata_q, sdata_d;

  always_comb begin
    lock_cnt_d   = lock_cnt_q;
    lock_next    = lock_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    phase_d      = phase_q;
    locked_d     = locked_q;
    upd_d        = 1'b0;
    slip_d       = 1'b0;
    sdata_d      = din_d[phase_q];
    if (!enable) begin
      lock_cnt_d   = '0;
      prev_valid_d = 1'b0;
      locked_d     = 1'b0;
      sdata_d      = 1'b0;
    end else if (window_done) begin
      if (total < SumW'(EDGE_MIN)) begin
        lock_cnt_d   = '0;
        locked_d     = 1'b0;
        prev_valid_d = 1'b0;
      end else begin
        if (!prev_valid_q || cand != prev_q) begin
          lock_next = LockW'(1);
        end else if (lock_cnt_q < LockW'(LOCK_COUNT)) begin
          lock_next = lock_cnt_q + LockW'(1);
        end
        prev_d       = cand;
        prev_valid_d = 1'b1;
        lock_cnt_d   = lock_next;
        locked_d     = 1'b0;
        if (lock_next == LockW'(LOCK_COUNT)) begin
          if (cand == phase_q) begin
            locked_d = 1'b1;
          end else begin
            phase_d    = phase_step(phase_q, cand);
            upd_d      = 1'b1;
            lock_cnt_d = '0;
            slip_d     = (phase_q == 2'd3 && phase_d == 2'd0) ||
                         (phase_q == 2'd0 && phase_d == 2'd3);
          end
        end
      end
    end
  end

  always_ff @(posedge clk400 or posedge reset) begin
    if (reset) begin
      lock_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      phase_q      <= '0;
      locked_q     <= 1'b0;
      upd_q        <= 1'b0;
      slip_q       <= 1'b0;
      sdata_q      <= 1'b0;
    end else begin
      lock_cnt_q   <= lock_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      phase_q      <= phase_d;
      locked_q     <= locked_d;
      upd_q        <= upd_d;
      slip_q       <= slip_d;
      sdata_q      <= sdata_d;
    end
  end

  assign sdata     = sdata_q;
  assign phase     = phase_q;
  assign locked    = locked_q;
  assign phase_upd = upd_q;
  assign slip      = slip_q;

endmodule

// File: tb/tb_phase_selector.sv
// Scoreboard bench for phase_selector: queued phase updates and sdata bits checked by a monitor.
module tb_phase_selector;

  logic       clk400 = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] din;
  logic       sdata, locked, phase_upd, slip;
  logic [1:0] phase;

  phase_selector #(
    .WINDOW_LOG2(6),
    .LOCK_COUNT (4),
    .EDGE_MIN   (4)
  ) dut (
    .clk400    (clk400),
    .reset     (reset),
    .enable    (enable),
    .din       (din),
    .sdata     (sdata),
    .phase     (phase),
    .locked    (locked),
    .phase_upd (phase_upd),
    .slip      (slip)
  );

  always #5 clk400 = ~clk400;

  int unsigned cyc = 0;
  always @(posedge clk400) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [1:0]  ph;
    logic        sl;
  } upd_t;

  typedef struct {
    int unsigned at;
    logic        bv;
  } bit_t;

  upd_t upd_q[$];
  bit_t bit_q[$];
  upd_t mon_u;
  bit_t mon_b;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: any pulse must match the head of the update queue, in value and in cycle.
  always @(negedge clk400) begin
    if (phase_upd || slip) begin
      check("upd_pending", 32'(upd_q.size() > 0), 1);
      if (upd_q.size() > 0) begin
        mon_u = upd_q.pop_front();
        check("upd_flag", phase_upd, 1);
        check("upd_phase", phase, mon_u.ph);
        check("upd_slip", slip, mon_u.sl);
        check("upd_cycle", cyc, mon_u.at);
      end
    end
    if (bit_q.size() > 0 && bit_q[0].at == cyc) begin
      mon_b = bit_q.pop_front();
      check("sdata", sdata, mon_b.bv);
    end
  end

  task automatic drive(input logic [3:0] v, input logic en, input logic track,
                       input logic [1:0] p);
    bit_t b;
    @(negedge clk400);
    din    = v;
    enable = en;
    if (track) begin
      b.at = cyc + 2;
      b.bv = v[p];
      bit_q.push_back(b);
    end
  endtask

  task automatic sync();
    @(posedge clk400);
    #1;
  endtask

  task automatic run_alt(input logic [3:0] a, input logic [3:0] b, input int nwin);
    for (int i = 0; i < 64 * nwin; i++) drive((i % 2) ? b : a, 1'b1, 1'b0, 2'd0);
    sync();
  endtask

  // Expected update at the end of window w, counted from the next enabled cycle.
  task automatic expect_upd(input int w, input logic [1:0] p, input logic s);
    upd_t u;
    u.at = cyc + 64 * w;
    u.ph = p;
    u.sl = s;
    upd_q.push_back(u);
  endtask

  // Three edges in total: below the validity threshold.
  task automatic low_window();
    drive(4'b1100, 1'b1, 1'b0, 2'd0);
    drive(4'b0001, 1'b1, 1'b0, 2'd0);
    drive(4'b1000, 1'b1, 1'b0, 2'd0);
    repeat (61) drive(4'b1111, 1'b1, 1'b0, 2'd0);
    sync();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sdata"}, sdata, 0);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_slip"}, slip, 0);
    check({tag, "_phase_upd"}, phase_upd, 0);
  endtask

  logic [3:0] vecs [8];

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    din    = 4'b0000;
    repeat (3) sync();
    check_reset_state("reset");
    @(negedge clk400);
    reset = 1'b0;

    // Idle line: no edges, never valid.
    repeat (1000) drive(4'b0000, 1'b1, 1'b0, 2'd0);
    repeat (2) drive(4'b0000, 1'b0, 1'b0, 2'd0);
    sync();
    check("idle_phase", phase, 0);
    check("idle_locked", locked, 0);

    // Edges at position 0 -> candidate 2, two steps from phase 0.
    expect_upd(4, 2'd1, 1'b0);
    expect_upd(8, 2'd2, 1'b0);
    run_alt(4'b0000, 4'b1111, 4);
    check("p0_phase_w4", phase, 1);
    check("p0_locked_w4", locked, 0);
    run_alt(4'b0000, 4'b1111, 4);
    check("p0_phase_w8", phase, 2);
    run_alt(4'b0000, 4'b1111, 3);
    check("p0_locked_w11", locked, 0);
    run_alt(4'b0000, 4'b1111, 1);
    check("p0_locked_w12", locked, 1);
    check("p0_upd_drained", upd_q.size(), 0);

    vecs = '{4'b0100, 4'b0000, 4'b1011, 4'b0110, 4'b0100, 4'b1111, 4'b0010, 4'b0000};
    foreach (vecs[i]) drive(vecs[i], 1'b1, 1'b1, 2'd2);
    repeat (2) drive(4'b0000, 1'b1, 1'b0, 2'd0);
    sync();
    check("sdata_drained", bit_q.size(), 0);

    @(negedge clk400);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) sync();
    @(negedge clk400);
    reset = 1'b0;
    sync();

    // Edges at position 1 -> candidate 3: wrap step 0->3 with slip.
    expect_upd(4, 2'd3, 1'b1);
    run_alt(4'b0001, 4'b1110, 4);
    check("p1_phase_w4", phase, 3);
    check("p1_locked_w4", locked, 0);
    run_alt(4'b0001, 4'b1110, 4);
    check("p1_locked_w8", locked, 1);
    check("p1_upd_drained", upd_q.size(), 0);

    // Tie between positions 0 and 2 -> candidate 2: step 3->2, no slip.
    expect_upd(4, 2'd2, 1'b0);
    run_alt(4'b0000, 4'b0011, 4);
    check("tie_phase_w4", phase, 2);
    run_alt(4'b0000, 4'b0011, 4);
    check("tie_locked_w8", locked, 1);
    low_window();
    check("low_locked", locked, 0);
    check("low_phase", phase, 2);
    run_alt(4'b0000, 4'b0011, 1);
    check("relock_w1", locked, 0);
    run_alt(4'b0000, 4'b0011, 2);
    check("relock_w3", locked, 0);
    run_alt(4'b0000, 4'b0011, 1);
    check("relock_w4", locked, 1);
    check("tie_upd_drained", upd_q.size(), 0);

    // Candidate flips every window: no movement, no lock.
    for (int i = 0; i < 4; i++) begin
      run_alt(4'b0001, 4'b1110, 1);
      check("flip_locked_a", locked, 0);
      run_alt(4'b0000, 4'b1111, 1);
      check("flip_locked_b", locked, 0);
    end
    check("flip_phase", phase, 2);
    check("flip_upd_drained", upd_q.size(), 0);

    // Enable low mid-window flushes lock; re-enable needs full hysteresis again.
    run_alt(4'b0000, 4'b1111, 4);
    check("en_locked_before", locked, 1);
    for (int i = 0; i < 20; i++) drive((i % 2) ? 4'b1111 : 4'b0000, 1'b1, 1'b0, 2'd0);
    repeat (10) drive(4'b1111, 1'b0, 1'b0, 2'd0);
    sync();
    check("dis_sdata", sdata, 0);
    check("dis_locked", locked, 0);
    check("dis_phase", phase, 2);
    run_alt(4'b0000, 4'b1111, 3);
    check("reen_locked_w3", locked, 0);
    run_alt(4'b0000, 4'b1111, 1);
    check("reen_locked_w4", locked, 1);
    check("reen_phase", phase, 2);

    // Reset mid-window.
    for (int i = 0; i < 30; i++) drive((i % 2) ? 4'b1111 : 4'b0000, 1'b1, 1'b0, 2'd0);
    @(negedge clk400);
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    sync();
    check_reset_state("midrst");
    @(negedge clk400);
    reset = 1'b0;
    sync();
    run_alt(4'b0000, 4'b1111, 2);
    check("post_rst_phase", phase, 0);
    check("post_rst_locked", locked, 0);
    check("final_upd_drained", upd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
